// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: sequences fetch/decode/execute/memory/writeback
// and drives the datapath load enables, memory strobes and a retired-instruction count.
module multicycle_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic [3:0]           OPCODE,
    input  logic                 TAKEN,
    input  logic                 MEM_RDY,
    output logic                 IR_EN,
    output logic                 PC_EN,
    output logic                 AB_EN,
    output logic                 ALU_EN,
    output logic                 MDR_EN,
    output logic                 RF_WE,
    output logic                 MEM_RD,
    output logic                 MEM_WR,
    output logic                 PC_SEL,
    output logic                 WB_SEL,
    output logic [2:0]           STATE,
    output logic                 BUSY,
    output logic [CNT_WIDTH-1:0] INSTR_CNT
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 retire;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic is_alu;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_halt;
    logic needs_exec;

    assign is_alu     = ~OPCODE[3];
    assign is_load    = (OPCODE == 4'h8);
    assign is_store   = (OPCODE == 4'h9);
    assign is_branch  = (OPCODE == 4'hA);
    assign is_halt    = (OPCODE == 4'hF);
    assign needs_exec = is_alu | is_load | is_store | is_branch;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory handshake: MEM_RD/MEM_WR act as a valid held high for every cycle of
    // the request; the transfer completes in the cycle MEM_RDY (ready) is also high,
    // and only that cycle may load IR/MDR or advance the state.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        IR_EN   = 1'b0;
        PC_EN   = 1'b0;
        AB_EN   = 1'b0;
        ALU_EN  = 1'b0;
        MDR_EN  = 1'b0;
        RF_WE   = 1'b0;
        MEM_RD  = 1'b0;
        MEM_WR  = 1'b0;
        PC_SEL  = 1'b0;
        WB_SEL  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                MEM_RD = 1'b1;
                if (MEM_RDY) begin
                    IR_EN   = 1'b1;
                    PC_EN   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                AB_EN = 1'b1;
                if (needs_exec) begin
                    state_d = S_EXEC;
                end else if (is_halt) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC: begin
                ALU_EN = 1'b1;
                if (is_alu) begin
                    state_d = S_WB;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_branch) begin
                    PC_EN   = TAKEN;
                    PC_SEL  = 1'b1;
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    // IR changed under us; refetch without counting anything
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (is_load) begin
                    MEM_RD = 1'b1;
                    if (MEM_RDY) begin
                        MDR_EN  = 1'b1;
                        state_d = S_WB;
                    end
                end else if (is_store) begin
                    MEM_WR = 1'b1;
                    if (MEM_RDY) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                RF_WE   = 1'b1;
                WB_SEL  = is_load;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_BAD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign STATE     = state_q;
    assign BUSY      = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                       (state_q == S_MEM) || (state_q == S_WB);
    assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle stimulus and expected output words are queued
// together, then replayed and compared at the falling edge.
module tb_multicycle_ctrl;

    localparam int CW = 4;

    localparam logic [2:0] ID = 3'd0, FE = 3'd1, DE = 3'd2, EX = 3'd3,
                           ME = 3'd4, WB = 3'd5, HA = 3'd6;

    // mask order: IR PC AB ALU MDR RF RD WR PCSEL WBSEL
    localparam logic [9:0] M_IR  = 10'b1000000000;
    localparam logic [9:0] M_PC  = 10'b0100000000;
    localparam logic [9:0] M_AB  = 10'b0010000000;
    localparam logic [9:0] M_ALU = 10'b0001000000;
    localparam logic [9:0] M_MDR = 10'b0000100000;
    localparam logic [9:0] M_RF  = 10'b0000010000;
    localparam logic [9:0] M_RD  = 10'b0000001000;
    localparam logic [9:0] M_WR  = 10'b0000000100;
    localparam logic [9:0] M_PS  = 10'b0000000010;
    localparam logic [9:0] M_WS  = 10'b0000000001;
    localparam logic [9:0] M_FT  = M_RD | M_IR | M_PC;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic          START = 1'b0;
    logic [3:0]    OPCODE = 4'h0;
    logic          TAKEN = 1'b0;
    logic          MEM_RDY = 1'b0;
    logic          IR_EN, PC_EN, AB_EN, ALU_EN, MDR_EN, RF_WE;
    logic          MEM_RD, MEM_WR, PC_SEL, WB_SEL;
    logic [2:0]    STATE;
    logic          BUSY;
    logic [CW-1:0] INSTR_CNT;

    multicycle_ctrl #(.CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .OPCODE(OPCODE), .TAKEN(TAKEN),
        .MEM_RDY(MEM_RDY), .IR_EN(IR_EN), .PC_EN(PC_EN), .AB_EN(AB_EN), .ALU_EN(ALU_EN),
        .MDR_EN(MDR_EN), .RF_WE(RF_WE), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
        .PC_SEL(PC_SEL), .WB_SEL(WB_SEL), .STATE(STATE), .BUSY(BUSY), .INSTR_CNT(INSTR_CNT)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       start;
        logic [3:0] op;
        logic       tk;
        logic       rdy;
    } stim_t;

    stim_t       stim_q[$];
    logic [17:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    logic [17:0] obs;
    assign obs = {STATE, BUSY, IR_EN, PC_EN, AB_EN, ALU_EN, MDR_EN, RF_WE,
                  MEM_RD, MEM_WR, PC_SEL, WB_SEL, INSTR_CNT};

    function automatic logic [17:0] mk(input logic [2:0] st, input logic [9:0] m,
                                       input logic [3:0] c);
        return {st, (st != ID) && (st != HA), m, c};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // driver tasks
    task automatic apply_reset();
        START   = 1'b0;
        MEM_RDY = 1'b0;
        RST_N   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    task automatic push(input logic start, input logic [3:0] op, input logic tk,
                        input logic rdy, input logic [2:0] st, input logic [9:0] m,
                        input logic [3:0] c);
        stim_t s;
        s.start = start;
        s.op    = op;
        s.tk    = tk;
        s.rdy   = rdy;
        stim_q.push_back(s);
        exp_q.push_back(mk(st, m, c));
    endtask

    task automatic test_reset();
        #2;
        START = 1'b1;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (obs !== mk(ID, 10'b0, 4'd0))
            $display("FAIL reset_async: got %b required %b", obs, mk(ID, 10'b0, 4'd0));
        else n_pass++;
        START = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            MEM_RDY = rnd_bit();
            OPCODE  = 4'($urandom_range(0, 15));
            @(negedge CLK);
            n_checks++;
            if (obs !== mk(ID, 10'b0, 4'd0))
                $display("FAIL reset_idle cyc%0d: got %b required %b", i, obs, mk(ID, 10'b0, 4'd0));
            else n_pass++;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_alu();
        stim_t s;
        logic [17:0] e;
        apply_reset();
        push(1, 4'h3, rnd_bit(), 1, ID, 10'b0, 0);
        push(1, 4'h3, rnd_bit(), 1, FE, M_FT, 0);
        push(1, 4'h3, rnd_bit(), 1, DE, M_AB, 0);
        push(1, 4'h3, rnd_bit(), 1, EX, M_ALU, 0);
        push(1, 4'h3, rnd_bit(), 1, WB, M_RF, 0);
        push(0, 4'h3, rnd_bit(), 1, FE, M_FT, 1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            START = s.start; OPCODE = s.op; TAKEN = s.tk; MEM_RDY = s.rdy;
            @(negedge CLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL alu cyc%0d: got %b required %b", i, obs, e);
            else n_pass++;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_load_wait();
        stim_t s;
        logic [17:0] e;
        apply_reset();
        push(1, 4'h8, rnd_bit(), 0, ID, 10'b0, 0);
        push(1, 4'h8, rnd_bit(), 0, FE, M_RD, 0);
        push(1, 4'h8, rnd_bit(), 0, FE, M_RD, 0);
        push(1, 4'h8, rnd_bit(), 1, FE, M_FT, 0);
        push(1, 4'h8, rnd_bit(), 0, DE, M_AB, 0);
        push(1, 4'h8, rnd_bit(), 1, EX, M_ALU, 0);
        for (int k = 0; k < 3; k++) push(1, 4'h8, rnd_bit(), 0, ME, M_RD, 0);
        push(1, 4'h8, rnd_bit(), 1, ME, M_RD | M_MDR, 0);
        push(1, 4'h8, rnd_bit(), 1, WB, M_RF | M_WS, 0);
        push(0, 4'h8, rnd_bit(), 0, FE, M_RD, 1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            START = s.start; OPCODE = s.op; TAKEN = s.tk; MEM_RDY = s.rdy;
            @(negedge CLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL load_wait cyc%0d: got %b required %b", i, obs, e);
            else n_pass++;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_store();
        stim_t s;
        logic [17:0] e;
        apply_reset();
        push(1, 4'h9, rnd_bit(), 1, ID, 10'b0, 0);
        push(0, 4'h9, rnd_bit(), 1, FE, M_FT, 0);
        push(0, 4'h9, rnd_bit(), 1, DE, M_AB, 0);
        push(0, 4'h9, rnd_bit(), 0, EX, M_ALU, 0);
        push(0, 4'h9, rnd_bit(), 0, ME, M_WR, 0);
        push(0, 4'h9, rnd_bit(), 1, ME, M_WR, 0);
        push(0, 4'h9, rnd_bit(), 0, FE, M_RD, 1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            START = s.start; OPCODE = s.op; TAKEN = s.tk; MEM_RDY = s.rdy;
            @(negedge CLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL store cyc%0d: got %b required %b", i, obs, e);
            else n_pass++;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        logic [17:0] e;
        apply_reset();
        push(1, 4'hA, rnd_bit(), 1, ID, 10'b0, 0);
        push(1, 4'hA, rnd_bit(), 1, FE, M_FT, 0);
        push(1, 4'hA, rnd_bit(), 1, DE, M_AB, 0);
        push(1, 4'hA, 1'b1, 1, EX, M_ALU | M_PC | M_PS, 0);
        push(1, 4'hA, rnd_bit(), 1, FE, M_FT, 1);
        push(1, 4'hA, rnd_bit(), 1, DE, M_AB, 1);
        push(1, 4'hA, 1'b0, 1, EX, M_ALU | M_PS, 1);
        push(0, 4'hA, rnd_bit(), 0, FE, M_RD, 2);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            START = s.start; OPCODE = s.op; TAKEN = s.tk; MEM_RDY = s.rdy;
            @(negedge CLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL branch cyc%0d: got %b required %b", i, obs, e);
            else n_pass++;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_nop_halt();
        stim_t s;
        logic [17:0] e;
        apply_reset();
        push(1, 4'hE, rnd_bit(), 1, ID, 10'b0, 0);
        push(0, 4'hE, rnd_bit(), 1, FE, M_FT, 0);
        push(0, 4'hE, rnd_bit(), 1, DE, M_AB, 0);
        push(0, 4'hF, rnd_bit(), 1, FE, M_FT, 1);
        push(0, 4'hF, rnd_bit(), 1, DE, M_AB, 1);
        push(1, 4'hF, rnd_bit(), 1, HA, 10'b0, 2);
        push(1, 4'hF, rnd_bit(), 1, HA, 10'b0, 2);
        push(0, 4'hF, rnd_bit(), 1, HA, 10'b0, 2);
        push(1, 4'h3, rnd_bit(), 1, HA, 10'b0, 2);
        push(0, 4'h3, rnd_bit(), 1, HA, 10'b0, 2);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            START = s.start; OPCODE = s.op; TAKEN = s.tk; MEM_RDY = s.rdy;
            @(negedge CLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL nop_halt cyc%0d: got %b required %b", i, obs, e);
            else n_pass++;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset_mid_mem();
        stim_t s;
        logic [17:0] e;
        apply_reset();
        push(1, 4'hB, rnd_bit(), 1, ID, 10'b0, 0);
        push(0, 4'hB, rnd_bit(), 1, FE, M_FT, 0);
        push(0, 4'hB, rnd_bit(), 1, DE, M_AB, 0);
        push(0, 4'h9, rnd_bit(), 1, FE, M_FT, 1);
        push(0, 4'h9, rnd_bit(), 1, DE, M_AB, 1);
        push(0, 4'h9, rnd_bit(), 0, EX, M_ALU, 1);
        push(0, 4'h9, rnd_bit(), 0, ME, M_WR, 1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            START = s.start; OPCODE = s.op; TAKEN = s.tk; MEM_RDY = s.rdy;
            @(negedge CLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL rst_mid_mem cyc%0d: got %b required %b", i, obs, e);
            else n_pass++;
            @(posedge CLK);
            #1;
        end
        // still in MEM waiting; pulse reset between edges
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (STATE !== ID) $display("FAIL rst_mid_mem_state: got %0d required 0", STATE);
        else n_pass++;
        n_checks++;
        if (MEM_WR !== 1'b0) $display("FAIL rst_mid_mem_wr: got %b required 0", MEM_WR);
        else n_pass++;
        n_checks++;
        if (INSTR_CNT !== 4'd0) $display("FAIL rst_mid_mem_cnt: got %0d required 0", INSTR_CNT);
        else n_pass++;
        #1;
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            START   = 1'b0;
            MEM_RDY = 1'b1;
            @(negedge CLK);
            n_checks++;
            if (obs !== mk(ID, 10'b0, 4'd0))
                $display("FAIL rst_mid_mem_idle cyc%0d: got %b required %b", i, obs, mk(ID, 10'b0, 4'd0));
            else n_pass++;
            @(posedge CLK);
            #1;
        end
        START   = 1'b0;
        MEM_RDY = 1'b0;
    endtask

    task automatic test_wrap();
        stim_t s;
        logic [17:0] e;
        logic [3:0]  op;
        apply_reset();
        push(1, 4'hB, rnd_bit(), 1, ID, 10'b0, 0);
        for (int k = 0; k < 17; k++) begin
            op = 4'($urandom_range(11, 14));
            push(0, op, rnd_bit(), 1, FE, M_FT, 4'(k));
            push(0, op, rnd_bit(), 1, DE, M_AB, 4'(k));
        end
        push(0, 4'hB, rnd_bit(), 0, FE, M_RD, 4'd1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            START = s.start; OPCODE = s.op; TAKEN = s.tk; MEM_RDY = s.rdy;
            @(negedge CLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL wrap cyc%0d: got %b required %b", i, obs, e);
            else n_pass++;
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_store();
        test_back_to_back();
        test_nop_halt();
        test_reset_mid_mem();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of the retired-instruction counter.
REQ-002 SHALL have port CLK, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port START, input, 1: begin execution from IDLE.
REQ-005 SHALL have port OPCODE, input, 4: opcode field from the IR register output.
REQ-006 SHALL have port TAKEN, input, 1: branch condition from the ALU flags.
REQ-007 SHALL have port MEM_RDY, input, 1: memory completes the current read or write this cycle.
REQ-008 SHALL have ports IR_EN, PC_EN, AB_EN, ALU_EN, MDR_EN, RF_WE, output, 1 each: load enables for the datapath registers and the regfile write.
REQ-009 SHALL have ports MEM_RD, MEM_WR, output, 1 each: memory request strobes.
REQ-010 SHALL have ports PC_SEL, WB_SEL, output, 1 each: PC source (0 = PC+4, 1 = branch target) and writeback source (0 = ALUOUT, 1 = MDR).
REQ-011 SHALL have ports STATE, output, 3, and BUSY, output, 1: current state and running indication.
REQ-012 SHALL have port INSTR_CNT, output, CNT_WIDTH: retired-instruction count.

Function
REQ-013 SHALL use these state encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; 7 is unreachable and SHALL return to IDLE on the next edge.
REQ-014 SHALL decode opcode classes as: ALU = 0x0-0x7, LOAD = 0x8, STORE = 0x9, BRANCH = 0xA, NOP = 0xB-0xE, HALT = 0xF.
REQ-015 SHALL drive all enable and strobe outputs as a combinational decode of STATE, OPCODE, TAKEN and MEM_RDY; each SHALL be 0 in any state not listed for it.
REQ-016 IDLE: all enables 0; SHALL go to FETCH on START=1, otherwise stay in IDLE.
REQ-017 FETCH: MEM_RD=1 for every cycle in the state; while MEM_RDY=0 SHALL stay in FETCH with IR_EN=PC_EN=0; in the cycle MEM_RDY=1 SHALL set IR_EN=1, PC_EN=1, PC_SEL=0, and go to DECODE.
REQ-018 DECODE: AB_EN=1 for one cycle; next state by OPCODE class: ALU/LOAD/STORE/BRANCH go to EXEC, NOP goes to FETCH and retires, HALT goes to HALT and retires.
REQ-019 EXEC: ALU_EN=1 for one cycle; ALU goes to WB; LOAD/STORE go to MEM; BRANCH drives PC_EN=TAKEN, PC_SEL=1, goes to FETCH and retires.
REQ-020 MEM, LOAD: MEM_RD=1 until MEM_RDY; in the MEM_RDY cycle SHALL set MDR_EN=1 and go to WB.
REQ-021 MEM, STORE: MEM_WR=1 until MEM_RDY; in the MEM_RDY cycle SHALL go to FETCH and retire.
REQ-022 WB: RF_WE=1 for exactly one cycle; WB_SEL=1 for LOAD, 0 for ALU; SHALL go to FETCH and retire.
REQ-023 HALT: all enables 0; SHALL stay in HALT, ignoring START, until RST_N is asserted.
REQ-024 MEM_RD and MEM_WR SHALL never both be 1; RF_WE and MDR_EN SHALL never both be 1.
REQ-025 Cycle counts with MEM_RDY=1 on the first request cycle: ALU 4, LOAD 5, STORE 4, BRANCH 3, NOP 2, HALT 2; each wait cycle adds exactly 1.
REQ-026 INSTR_CNT SHALL increment by 1 on each retiring edge and wrap from 2^CNT_WIDTH-1 to 0 without flag.
REQ-027 BUSY SHALL be 1 in states FETCH through WB, and 0 in IDLE and HALT.
REQ-028 START asserted while BUSY=1 SHALL be ignored.

Reset
REQ-029 RST_N=0 SHALL immediately, without waiting for CLK, force STATE=IDLE and INSTR_CNT=0; all enables, strobes, PC_SEL, WB_SEL and BUSY then read 0.
REQ-030 Reset asserted mid-instruction, including during a memory wait, SHALL abort the instruction without retiring it and with no further enable pulses.
REQ-031 After RST_N deasserts, the block SHALL remain in IDLE until START=1.

Verification
REQ-032 ALU: reset, START, OPCODE=0x3, MEM_RDY=1 -> STATE 1,2,3,5,1; RF_WE one cycle with WB_SEL=0; INSTR_CNT=1 after 4 cycles.
REQ-033 LOAD with waits: OPCODE=0x8, MEM_RDY low 2 cycles in FETCH and 3 in MEM -> MEM_RD held throughout; IR_EN and MDR_EN pulse once each; RF_WE with WB_SEL=1; retires after 10 cycles.
REQ-034 BRANCH: OPCODE=0xA with TAKEN=1 -> EXEC drives PC_EN=1, PC_SEL=1; with TAKEN=0 -> PC_EN=0 in EXEC; both retire after 3 cycles.
REQ-035 HALT/NOP: OPCODE=0xE -> FETCH after 2 cycles, INSTR_CNT+1; OPCODE=0xF -> HALT, BUSY=0; START pulses leave STATE=6.
REQ-036 Reset mid-MEM, STORE with MEM_RDY=0, RST_N pulsed low between edges -> STATE=0 and MEM_WR=0 immediately; INSTR_CNT=0.
REQ-037 Wrap: CNT_WIDTH=4, 17 NOPs -> INSTR_CNT reads 15 then 0 then 1.
